// File: rtl/flash_read_arbiter.sv
// Two-requester round-robin read arbiter in front of a single Avalon flash master.
// One outstanding read at a time; a read with no data return is abandoned after TIMEOUT cycles.
module flash_read_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_read,
    input  logic [22:0] req0_address,
    output logic        req0_waitrequest,
    output logic [31:0] req0_readdata,
    output logic        req0_readdatavalid,
    input  logic        req1_read,
    input  logic [22:0] req1_address,
    output logic        req1_waitrequest,
    output logic [31:0] req1_readdata,
    output logic        req1_readdatavalid,
    output logic        flash_mem_read,
    output logic [22:0] flash_mem_address,
    output logic        flash_mem_write,
    output logic [3:0]  flash_mem_byteenable,
    output logic [31:0] flash_mem_writedata,
    output logic [5:0]  flash_mem_burstcount,
    input  logic        flash_mem_waitrequest,
    input  logic [31:0] flash_mem_readdata,
    input  logic        flash_mem_readdatavalid,
    output logic        grant,
    output logic        busy,
    output logic        timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 32'd1);

    state_t      state_r, state_nxt_s;
    logic        grant_r, grant_nxt_s;
    logic        last_r, last_nxt_s;
    logic [22:0] addr_r, addr_nxt_s;
    logic        read_r, read_nxt_s;
    logic [15:0] cnt_r, cnt_nxt_s;
    logic        timeout_r, timeout_nxt_s;
    logic        busy_r;
    logic        winner_s;
    logic        issue_s;
    logic        wait_s;

    // Round-robin pick: on a tie the requester not granted last time wins
    always_comb begin
        if (req0_read && req1_read) begin
            winner_s = ~last_r;
        end else if (req1_read) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // Next-state and next-register logic for the read sequencer
    always_comb begin
        state_nxt_s   = state_r;
        grant_nxt_s   = grant_r;
        last_nxt_s    = last_r;
        addr_nxt_s    = addr_r;
        read_nxt_s    = read_r;
        cnt_nxt_s     = cnt_r;
        timeout_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req0_read || req1_read) begin
                    state_nxt_s = ST_ISSUE;
                    grant_nxt_s = winner_s;
                    addr_nxt_s  = winner_s ? req1_address : req0_address;
                    read_nxt_s  = 1'b1;
                end else begin
                    read_nxt_s  = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (!flash_mem_waitrequest) begin
                    state_nxt_s = ST_WAIT;
                    read_nxt_s  = 1'b0;
                    cnt_nxt_s   = 16'd0;
                end else begin
                    read_nxt_s  = 1'b1;
                end
            end
            ST_WAIT: begin
                // Returned data takes priority over an expiring count
                if (flash_mem_readdatavalid) begin
                    state_nxt_s = ST_IDLE;
                    last_nxt_s  = grant_r;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    state_nxt_s   = ST_IDLE;
                    last_nxt_s    = grant_r;
                    timeout_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + 16'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                read_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            grant_r   <= 1'b0;
            last_r    <= 1'b1;
            addr_r    <= 23'd0;
            read_r    <= 1'b0;
            cnt_r     <= 16'd0;
            timeout_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            grant_r   <= grant_nxt_s;
            last_r    <= last_nxt_s;
            addr_r    <= addr_nxt_s;
            read_r    <= read_nxt_s;
            cnt_r     <= cnt_nxt_s;
            timeout_r <= timeout_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
        end
    end

    assign issue_s = (state_r == ST_ISSUE);
    assign wait_s  = (state_r == ST_WAIT);

    assign req0_waitrequest   = !(issue_s && !grant_r) || flash_mem_waitrequest;
    assign req1_waitrequest   = !(issue_s && grant_r) || flash_mem_waitrequest;
    assign req0_readdata      = flash_mem_readdata;
    assign req1_readdata      = flash_mem_readdata;
    assign req0_readdatavalid = flash_mem_readdatavalid && wait_s && !grant_r;
    assign req1_readdatavalid = flash_mem_readdatavalid && wait_s && grant_r;

    assign flash_mem_read       = read_r;
    assign flash_mem_address    = addr_r;
    assign flash_mem_write      = 1'b0;
    assign flash_mem_byteenable = 4'hF;
    assign flash_mem_writedata  = 32'h0000_0000;
    assign flash_mem_burstcount = 6'd1;

    assign grant   = grant_r;
    assign busy    = busy_r;
    assign timeout = timeout_r;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter: transaction-level reference model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_flash_read_arbiter;

    localparam int TMO = 8;
    localparam int P_IDLE  = 0;
    localparam int P_ISSUE = 1;
    localparam int P_WAIT  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_read, req1_read;
    logic [22:0] req0_address, req1_address;
    logic        req0_waitrequest, req1_waitrequest;
    logic [31:0] req0_readdata, req1_readdata;
    logic        req0_readdatavalid, req1_readdatavalid;
    logic        flash_mem_read, flash_mem_write;
    logic [22:0] flash_mem_address;
    logic [3:0]  flash_mem_byteenable;
    logic [31:0] flash_mem_writedata;
    logic [5:0]  flash_mem_burstcount;
    logic        fwr, frdv;
    logic [31:0] frd;
    logic        grant, busy, timeout;

    flash_read_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req0_read(req0_read), .req0_address(req0_address),
        .req0_waitrequest(req0_waitrequest), .req0_readdata(req0_readdata),
        .req0_readdatavalid(req0_readdatavalid),
        .req1_read(req1_read), .req1_address(req1_address),
        .req1_waitrequest(req1_waitrequest), .req1_readdata(req1_readdata),
        .req1_readdatavalid(req1_readdatavalid),
        .flash_mem_read(flash_mem_read), .flash_mem_address(flash_mem_address),
        .flash_mem_write(flash_mem_write), .flash_mem_byteenable(flash_mem_byteenable),
        .flash_mem_writedata(flash_mem_writedata), .flash_mem_burstcount(flash_mem_burstcount),
        .flash_mem_waitrequest(fwr), .flash_mem_readdata(frd),
        .flash_mem_readdatavalid(frdv),
        .grant(grant), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int pass_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Values seen by the DUT at each rising edge
    logic        samp_rst = 1'b0;
    logic [1:0]  samp_req = 2'b00;
    logic [22:0] samp_a0 = 23'd0, samp_a1 = 23'd0, samp_faddr = 23'd0;
    logic        samp_fwr = 1'b1, samp_rdv = 1'b0, samp_fmr = 1'b0;
    logic [1:0]  samp_wr = 2'b11;
    always @(posedge clk) begin
        samp_rst   <= rst;
        samp_req   <= {req1_read, req0_read};
        samp_a0    <= req0_address;
        samp_a1    <= req1_address;
        samp_fwr   <= fwr;
        samp_rdv   <= frdv;
        samp_fmr   <= flash_mem_read;
        samp_faddr <= flash_mem_address;
        samp_wr    <= {req1_waitrequest, req0_waitrequest};
    end

    // Reference model state and event log
    int          m_phase = P_IDLE;
    logic        m_owner = 1'b0;
    logic        m_last = 1'b1;
    logic [22:0] m_addr = 23'd0;
    int          m_waited = 0;
    logic        m_to = 1'b0;
    int          cyc = 0, acc_cnt = 0, acc_cyc = 0, to_cnt = 0, to_cyc = 0;
    int          wr0_low_cnt = 0, wr1_low_cnt = 0, fmr_high_cnt = 0;
    logic [22:0] acc_addr_q[$];
    int          served_n_q[$];
    logic [31:0] served_d_q[$];

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            m_phase = P_IDLE; m_owner = 1'b0; m_last = 1'b1; m_waited = 0; m_to = 1'b0;
            chk("rst_fm_read", flash_mem_read, 32'd0);
            chk("rst_fm_addr", flash_mem_address, 32'd0);
            chk("rst_grant", grant, 32'd0);
            chk("rst_busy", busy, 32'd0);
            chk("rst_timeout", timeout, 32'd0);
            chk("rst_rdv", {req1_readdatavalid, req0_readdatavalid}, 32'd0);
            chk("rst_wr", {req1_waitrequest, req0_waitrequest}, 32'd3);
        end else begin
            m_to = 1'b0;
            if (samp_rst) begin
                case (m_phase)
                    P_IDLE: if (samp_req != 2'b00) begin
                        if (samp_req == 2'b11) m_owner = ~m_last;
                        else m_owner = samp_req[1];
                        m_addr  = m_owner ? samp_a1 : samp_a0;
                        m_phase = P_ISSUE;
                    end
                    P_ISSUE: if (!samp_fwr) begin
                        m_phase = P_WAIT; m_waited = 0;
                    end
                    P_WAIT: if (samp_rdv) begin
                        m_phase = P_IDLE; m_last = m_owner;
                    end else begin
                        m_waited++;
                        if (m_waited == TMO) begin
                            m_to = 1'b1; m_phase = P_IDLE; m_last = m_owner;
                        end
                    end
                    default: m_phase = P_IDLE;
                endcase
            end
            chk("busy", busy, 32'(m_phase != P_IDLE));
            chk("grant", grant, 32'(m_owner));
            chk("fm_read", flash_mem_read, 32'(m_phase == P_ISSUE));
            if (m_phase == P_ISSUE) chk("fm_addr", flash_mem_address, 32'(m_addr));
            chk("wr0", req0_waitrequest, 32'(!(m_phase == P_ISSUE && m_owner == 1'b0 && !fwr)));
            chk("wr1", req1_waitrequest, 32'(!(m_phase == P_ISSUE && m_owner == 1'b1 && !fwr)));
            chk("rdv0", req0_readdatavalid, 32'(frdv && m_phase == P_WAIT && m_owner == 1'b0));
            chk("rdv1", req1_readdatavalid, 32'(frdv && m_phase == P_WAIT && m_owner == 1'b1));
            chk("timeout", timeout, 32'(m_to));
            chk("rdata0", req0_readdata, frd);
            chk("rdata1", req1_readdata, frd);
            chk("fm_const", {flash_mem_write, flash_mem_byteenable, flash_mem_burstcount},
                {21'd0, 1'b0, 4'hF, 6'd1});
            chk("fm_wdata", flash_mem_writedata, 32'd0);
            if (flash_mem_read) fmr_high_cnt++;
            if (flash_mem_read && !fwr) begin
                acc_cnt++; acc_cyc = cyc; acc_addr_q.push_back(flash_mem_address);
            end
            if (!req0_waitrequest) wr0_low_cnt++;
            if (!req1_waitrequest) wr1_low_cnt++;
            if (req0_readdatavalid) begin served_n_q.push_back(0); served_d_q.push_back(req0_readdata); end
            if (req1_readdatavalid) begin served_n_q.push_back(1); served_d_q.push_back(req1_readdata); end
            if (timeout) begin to_cnt++; to_cyc = cyc; end
        end
    end

    // Flash slave and requester behaviour configuration
    int          cfg_hold = 0, cfg_lat = 2, hold_cnt = 0, lat_cnt = 0;
    logic        cfg_respond = 1'b1, force_rdv = 1'b0;
    logic [31:0] cfg_xor = 32'd0, force_data = 32'd0;
    logic [22:0] lat_addr = 23'd0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (samp_rst && samp_req[0] && !samp_wr[0]) req0_read = 1'b0;
        if (samp_rst && samp_req[1] && !samp_wr[1]) req1_read = 1'b0;
        if (flash_mem_read) begin
            fwr = (hold_cnt < cfg_hold);
            hold_cnt++;
        end else begin
            fwr = 1'b1; hold_cnt = 0;
        end
        frdv = 1'b0;
        frd  = $urandom;
        if (!rst) begin
            lat_cnt = 0;
        end else if (samp_rst && samp_fmr && !samp_fwr && cfg_respond) begin
            lat_cnt = cfg_lat; lat_addr = samp_faddr;
        end else if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin frdv = 1'b1; frd = cfg_xor ^ {9'd0, lat_addr}; end
        end
        if (force_rdv) begin frdv = 1'b1; frd = force_data; force_rdv = 1'b0; end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue(input int n, input logic [22:0] a);
        if (n == 0) begin req0_read = 1'b1; req0_address = a; end
        else begin req1_read = 1'b1; req1_address = a; end
    endtask

    task automatic wait_served(input int target, input int budget);
        int b = 0;
        while (served_n_q.size() < target && b < budget) begin tick(); b++; end
        if (served_n_q.size() < target) chk("wait_served", served_n_q.size(), target);
    endtask

    task automatic wait_acc(input int target, input int budget);
        int b = 0;
        while (acc_cnt < target && b < budget) begin tick(); b++; end
        if (acc_cnt < target) chk("wait_acc", acc_cnt, target);
    endtask

    task automatic wait_to(input int target, input int budget);
        int b = 0;
        while (to_cnt < target && b < budget) begin tick(); b++; end
        if (to_cnt < target) chk("wait_to", to_cnt, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end, expected finish");
        $fatal(1);
    end

    initial begin
        int b, w0, fh, na;
        rst = 1'b0; req0_read = 1'b0; req1_read = 1'b0;
        req0_address = 23'd0; req1_address = 23'd0;
        fwr = 1'b1; frdv = 1'b0; frd = 32'd0;
        idle(3);
        chk("init_grant", grant, 32'd0);
        chk("init_wr", {req1_waitrequest, req0_waitrequest}, 32'd3);
        rst = 1'b1;
        idle(2);

        // Two simultaneous pairs straight after reset: req0 first each time
        cfg_xor = 32'd0; cfg_lat = 2; cfg_hold = 0;
        issue(0, 23'h000100); issue(1, 23'h000200);
        wait_served(2, 60);
        issue(0, 23'h000100); issue(1, 23'h000200);
        wait_served(4, 60);
        idle(2);
        chk("pair_n0", served_n_q[0], 32'd0);
        chk("pair_n1", served_n_q[1], 32'd1);
        chk("pair_n2", served_n_q[2], 32'd0);
        chk("pair_n3", served_n_q[3], 32'd1);
        chk("pair_d1", served_d_q[1], 32'h00000200);
        chk("pair_d2", served_d_q[2], 32'h00000100);

        // Single read, data three cycles after acceptance
        b = served_n_q.size(); w0 = wr0_low_cnt; na = acc_cnt;
        cfg_xor = 32'h0000ABDD; cfg_lat = 3;
        issue(0, 23'h000010);
        wait_served(b + 1, 40);
        idle(3);
        chk("single_acc_addr", acc_addr_q[na], 32'h10);
        chk("single_acc_cnt", acc_cnt - na, 32'd1);
        chk("single_owner", served_n_q[b], 32'd0);
        chk("single_data", served_d_q[b], 32'h0000ABCD);
        chk("single_wr0_low", wr0_low_cnt - w0, 32'd1);
        chk("single_served_cnt", served_n_q.size() - b, 32'd1);

        // Flash stalls five cycles; stray data during ISSUE must be ignored
        b = served_n_q.size(); w0 = wr0_low_cnt; fh = fmr_high_cnt;
        cfg_xor = 32'd0; cfg_lat = 1; cfg_hold = 5;
        issue(0, 23'h000055);
        tick(); tick();
        force_rdv = 1'b1; force_data = 32'hFEEDF00D;
        wait_served(b + 1, 40);
        idle(3);
        chk("stall_wr0_low", wr0_low_cnt - w0, 32'd1);
        chk("stall_read_cycles", fmr_high_cnt - fh, 32'd6);
        chk("stall_served_cnt", served_n_q.size() - b, 32'd1);
        chk("stall_data", served_d_q[b], 32'h00000055);

        // No data return: abandon after TMO cycles, pending req1 granted next
        cfg_hold = 0; cfg_respond = 1'b0; cfg_lat = 2;
        b = served_n_q.size(); na = acc_cnt;
        issue(0, 23'h000077);
        wait_acc(na + 1, 20);
        cfg_respond = 1'b1;
        issue(1, 23'h000088);
        wait_to(1, 40);
        // acceptance cycle, then 8 WAIT cycles, then the pulse cycle
        chk("to_distance", to_cyc - acc_cyc, 32'd9);
        wait_served(b + 1, 40);
        idle(3);
        chk("to_count", to_cnt, 32'd1);
        chk("to_next_owner", served_n_q[b], 32'd1);
        chk("to_next_addr", acc_addr_q[na + 1], 32'h88);

        // Stray data strobe while idle
        force_rdv = 1'b1; force_data = 32'h12345678;
        tick();
        #1;
        chk("stray_rdv", {req1_readdatavalid, req0_readdatavalid}, 32'd0);
        chk("stray_busy", busy, 32'd0);
        chk("stray_bcast", req0_readdata, 32'h12345678);
        idle(2);

        // req0 served last, then a reset in WAIT must restore the req0 tie preference
        b = served_n_q.size();
        issue(0, 23'h00003F);
        wait_served(b + 1, 40);
        idle(2);
        cfg_respond = 1'b0; na = acc_cnt;
        issue(0, 23'h000099);
        wait_acc(na + 1, 20);
        tick(); tick();
        #1;
        rst = 1'b0;
        #1;
        chk("arst_fm_read", flash_mem_read, 32'd0);
        chk("arst_fm_addr", flash_mem_address, 32'd0);
        chk("arst_busy", busy, 32'd0);
        chk("arst_grant", grant, 32'd0);
        chk("arst_wr", {req1_waitrequest, req0_waitrequest}, 32'd3);
        req0_read = 1'b0; req1_read = 1'b0;
        idle(2);
        rst = 1'b1;
        b = served_n_q.size();
        force_rdv = 1'b1; force_data = 32'hCAFE0099;
        idle(3);
        chk("post_rst_stray", served_n_q.size() - b, 32'd0);
        cfg_respond = 1'b1;
        issue(0, 23'h0001AB); issue(1, 23'h0002CD);
        wait_served(b + 2, 60);
        idle(3);
        chk("post_rst_first", served_n_q[b], 32'd0);
        chk("post_rst_second", served_n_q[b + 1], 32'd1);
        chk("post_rst_data", served_d_q[b + 1], 32'h000002CD);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
